vx_dma_scheduler: RTL and testbench

Shares a single DMA engine request/response port among NUM_REQS requesters (e.g. per-core or per-warp DMA units) using round-robin arbitration. Each accepted request gets a free internal engine tag (slot ID). A slot table maps each slot back to its requester and original tag. Engine completions are routed to the owning requester, and per-requester outstanding limits and busy flags are maintained.

---
 rtl/vx_dma_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_vx_dma_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dma_scheduler.sv
// vx_dma_scheduler: shares one DMA engine port among NUM_REQS requesters.
// Requests are picked round-robin, each gets a free engine tag (slot), and
// engine completions are routed back to the owner with its original tag.
module vx_dma_scheduler #(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int SIZE_WIDTH  = 16,
  parameter int TAG_WIDTH   = 8,
  parameter int NUM_SLOTS   = 8,
  parameter int MAX_PER_REQ = 4,
  localparam int SLOT_W     = $clog2(NUM_SLOTS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQS-1:0]              req_valid,
  output logic [NUM_REQS-1:0]              req_ready,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_src_addr,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_dst_addr,
  input  logic [NUM_REQS*SIZE_WIDTH-1:0]   req_size,
  input  logic [NUM_REQS-1:0]              req_dir,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag,
  output logic                             dma_req_valid,
  input  logic                             dma_req_ready,
  output logic [ADDR_WIDTH-1:0]            dma_req_src_addr,
  output logic [ADDR_WIDTH-1:0]            dma_req_dst_addr,
  output logic [SIZE_WIDTH-1:0]            dma_req_size,
  output logic                             dma_req_dir,
  output logic [SLOT_W-1:0]                dma_req_tag,
  input  logic                             dma_rsp_valid,
  input  logic [SLOT_W-1:0]                dma_rsp_tag,
  output logic                             dma_rsp_ready,
  output logic [NUM_REQS-1:0]              rsp_valid,
  output logic [TAG_WIDTH-1:0]             rsp_tag,
  input  logic [NUM_REQS-1:0]              rsp_ready,
  output logic [NUM_REQS-1:0]              busy,
  output logic                             idle,
  output logic                             err_bad_tag
);

  localparam int REQ_W = $clog2(NUM_REQS);
  localparam int CNT_W = $clog2(MAX_PER_REQ + 1);

  // slot table: which slots are in flight, and who owns them
  logic [NUM_SLOTS-1:0]  r_used;
  logic [REQ_W-1:0]      r_owner [NUM_SLOTS];
  logic [TAG_WIDTH-1:0]  r_otag  [NUM_SLOTS];
  logic [REQ_W-1:0]      r_rr_ptr;

  // request output stage towards the engine
  logic                  r_dreq_valid;
  logic [ADDR_WIDTH-1:0] r_dreq_src;
  logic [ADDR_WIDTH-1:0] r_dreq_dst;
  logic [SIZE_WIDTH-1:0] r_dreq_size;
  logic                  r_dreq_dir;
  logic [SLOT_W-1:0]     r_dreq_tag;

  // response output stage towards the requesters
  logic [NUM_REQS-1:0]   r_rsp_valid;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;
  logic                  r_err;

  // per-requester payload views and handshake terms
  logic [ADDR_WIDTH-1:0] w_src  [NUM_REQS];
  logic [ADDR_WIDTH-1:0] w_dst  [NUM_REQS];
  logic [SIZE_WIDTH-1:0] w_size [NUM_REQS];
  logic [TAG_WIDTH-1:0]  w_tag  [NUM_REQS];
  logic [NUM_REQS-1:0]   w_elig;
  logic [NUM_REQS-1:0]   w_inc;
  logic [NUM_REQS-1:0]   w_dec;

  logic                  w_stage_free;
  logic                  w_slot_avail;
  logic                  w_grant;
  logic [REQ_W-1:0]      w_winner;
  logic [SLOT_W-1:0]     w_alloc_slot;
  logic                  w_rsp_out_fire;
  logic                  w_dma_rsp_ready;
  logic                  w_dma_rsp_fire;
  logic                  w_rsp_hit;
  logic                  w_rsp_bad;
  logic [REQ_W-1:0]      w_rsp_owner;

  assign w_stage_free   = ~r_dreq_valid | dma_req_ready;
  assign w_slot_avail   = ~&r_used;
  assign w_rsp_out_fire = |(r_rsp_valid & rsp_ready);
  assign w_dma_rsp_ready = ~|r_rsp_valid | w_rsp_out_fire;
  assign w_dma_rsp_fire = dma_rsp_valid & w_dma_rsp_ready;
  assign w_rsp_hit      = w_dma_rsp_fire & r_used[dma_rsp_tag];
  assign w_rsp_bad      = w_dma_rsp_fire & ~r_used[dma_rsp_tag];
  assign w_rsp_owner    = r_owner[dma_rsp_tag];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_req
      logic [CNT_W-1:0] r_count;

      assign w_src[gi]  = req_src_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_dst[gi]  = req_dst_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_size[gi] = req_size[gi*SIZE_WIDTH +: SIZE_WIDTH];
      assign w_tag[gi]  = req_tag[gi*TAG_WIDTH +: TAG_WIDTH];

      assign w_elig[gi] = req_valid[gi] & (r_count < CNT_W'(MAX_PER_REQ)) &
                          w_slot_avail & w_stage_free;
      assign w_inc[gi]  = w_grant & (w_winner == REQ_W'(gi));
      assign w_dec[gi]  = w_rsp_hit & (w_rsp_owner == REQ_W'(gi));

      // in-flight count; a grant and a completion in one cycle cancel out
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_count <= '0;
        end else if (w_inc[gi] && !w_dec[gi]) begin
          r_count <= r_count + 1'b1;
        end else if (w_dec[gi] && !w_inc[gi]) begin
          r_count <= r_count - 1'b1;
        end
      end

      assign busy[gi]      = (r_count != '0);
      assign req_ready[gi] = w_inc[gi];
    end
  endgenerate

  // round-robin pick: first eligible requester at or after the pointer
  always_comb begin
    int idx;
    idx      = 0;
    w_grant  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQS;
      if (!w_grant && w_elig[idx]) begin
        w_grant  = 1'b1;
        w_winner = REQ_W'(idx);
      end
    end
  end

  // lowest-index free slot from the registered mask
  always_comb begin
    w_alloc_slot = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!r_used[s]) begin
        w_alloc_slot = SLOT_W'(s);
      end
    end
  end

  // round-robin pointer moves past the winner, holds otherwise
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_winner == REQ_W'(NUM_REQS - 1)) ? '0 : w_winner + 1'b1;
    end
  end

  // slot occupancy; the allocated slot was free pre-edge so it never
  // collides with the slot being released
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_used <= '0;
    end else begin
      if (w_grant) begin
        r_used[w_alloc_slot] <= 1'b1;
      end
      if (w_rsp_hit) begin
        r_used[dma_rsp_tag] <= 1'b0;
      end
    end
  end

  // slot table contents, only meaningful while the slot is marked used
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_owner[w_alloc_slot] <= w_winner;
      r_otag[w_alloc_slot]  <= w_tag[w_winner];
    end
  end

  // engine request stage valid: load on grant, drop once the engine accepts
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dreq_valid <= 1'b0;
    end else if (w_grant) begin
      r_dreq_valid <= 1'b1;
    end else if (dma_req_ready) begin
      r_dreq_valid <= 1'b0;
    end
  end

  // engine request payload, held until the stage drains
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_dreq_src  <= w_src[w_winner];
      r_dreq_dst  <= w_dst[w_winner];
      r_dreq_size <= w_size[w_winner];
      r_dreq_dir  <= req_dir[w_winner];
      r_dreq_tag  <= w_alloc_slot;
    end
  end

  // response stage: one-hot toward the owning requester with its tag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rsp_valid <= '0;
      r_rsp_tag   <= '0;
    end else if (w_rsp_hit) begin
      r_rsp_valid <= NUM_REQS'(1) << w_rsp_owner;
      r_rsp_tag   <= r_otag[dma_rsp_tag];
    end else if (w_rsp_out_fire) begin
      r_rsp_valid <= '0;
    end
  end

  // sticky flag for completions that name a slot not in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_rsp_bad) begin
      r_err <= 1'b1;
    end
  end

  assign dma_req_valid    = r_dreq_valid;
  assign dma_req_src_addr = r_dreq_src;
  assign dma_req_dst_addr = r_dreq_dst;
  assign dma_req_size     = r_dreq_size;
  assign dma_req_dir      = r_dreq_dir;
  assign dma_req_tag      = r_dreq_tag;
  assign dma_rsp_ready    = w_dma_rsp_ready;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_tag          = r_rsp_tag;
  assign idle             = ~|r_used & ~r_dreq_valid & ~|r_rsp_valid;
  assign err_bad_tag      = r_err;

endmodule

// File: tb/tb_vx_dma_scheduler.sv
// Bench for vx_dma_scheduler: directed scenarios with literal expectations
// plus randomized traffic, all compared each cycle against a slot-table model.
module tb_vx_dma_scheduler;

  localparam int NR   = 4;
  localparam int NS   = 8;
  localparam int MAXP = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*32-1:0] req_src_addr;
  logic [NR*32-1:0] req_dst_addr;
  logic [NR*16-1:0] req_size;
  logic [NR-1:0]   req_dir;
  logic [NR*8-1:0] req_tag;
  logic            dma_req_valid;
  logic            dma_req_ready;
  logic [31:0]     dma_req_src_addr;
  logic [31:0]     dma_req_dst_addr;
  logic [15:0]     dma_req_size;
  logic            dma_req_dir;
  logic [2:0]      dma_req_tag;
  logic            dma_rsp_valid;
  logic [2:0]      dma_rsp_tag;
  logic            dma_rsp_ready;
  logic [NR-1:0]   rsp_valid;
  logic [7:0]      rsp_tag;
  logic [NR-1:0]   rsp_ready;
  logic [NR-1:0]   busy;
  logic            idle;
  logic            err_bad_tag;

  vx_dma_scheduler dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_src_addr     (req_src_addr),
    .req_dst_addr     (req_dst_addr),
    .req_size         (req_size),
    .req_dir          (req_dir),
    .req_tag          (req_tag),
    .dma_req_valid    (dma_req_valid),
    .dma_req_ready    (dma_req_ready),
    .dma_req_src_addr (dma_req_src_addr),
    .dma_req_dst_addr (dma_req_dst_addr),
    .dma_req_size     (dma_req_size),
    .dma_req_dir      (dma_req_dir),
    .dma_req_tag      (dma_req_tag),
    .dma_rsp_valid    (dma_rsp_valid),
    .dma_rsp_tag      (dma_rsp_tag),
    .dma_rsp_ready    (dma_rsp_ready),
    .rsp_valid        (rsp_valid),
    .rsp_tag          (rsp_tag),
    .rsp_ready        (rsp_ready),
    .busy             (busy),
    .idle             (idle),
    .err_bad_tag      (err_bad_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_on = 1'b0;
  bit          m_used  [NS];
  int          m_owner [NS];
  logic [7:0]  m_otag  [NS];
  int          m_cnt   [NR];
  int          m_ptr;
  bit          m_dv;
  logic [31:0] m_dsrc, m_ddst;
  logic [15:0] m_dsize;
  logic        m_ddir;
  logic [2:0]  m_dtag;
  int          m_rv;
  logic [7:0]  m_rtag;
  bit          m_err;

  always @(negedge clk) begin : model
    int nfree, slot, grant, ii, t, o;
    bit sfree, in_rdy, out_fire;
    logic [NR-1:0] e_busy;
    if (m_on) begin
      sfree = !m_dv || (dma_req_ready == 1'b1);
      nfree = 0;
      slot  = -1;
      for (int s = 0; s < NS; s++) begin
        if (!m_used[s]) begin
          nfree++;
          if (slot < 0) slot = s;
        end
      end
      grant = -1;
      if (sfree && nfree > 0) begin
        for (int k = 0; k < NR; k++) begin
          ii = (m_ptr + k) % NR;
          if (grant < 0 && req_valid[ii] && m_cnt[ii] < MAXP) grant = ii;
        end
      end
      in_rdy   = (m_rv < 0) || (rsp_ready[m_rv] == 1'b1);
      out_fire = (m_rv >= 0) && (rsp_ready[m_rv] == 1'b1);
      e_busy   = '0;
      for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) e_busy[i] = 1'b1;

      check("req_ready", 128'(req_ready), (grant < 0) ? 128'(0) : 128'(1) << grant);
      check("dma_req_valid", 128'(dma_req_valid), 128'(m_dv));
      if (m_dv) begin
        check("dma_req_payload",
              128'({dma_req_src_addr, dma_req_dst_addr, dma_req_size, dma_req_dir, dma_req_tag}),
              128'({m_dsrc, m_ddst, m_dsize, m_ddir, m_dtag}));
      end
      check("dma_rsp_ready", 128'(dma_rsp_ready), 128'(in_rdy));
      check("rsp_valid", 128'(rsp_valid), (m_rv < 0) ? 128'(0) : 128'(1) << m_rv);
      if (m_rv >= 0) check("rsp_tag", 128'(rsp_tag), 128'(m_rtag));
      check("busy", 128'(busy), 128'(e_busy));
      check("idle", 128'(idle), 128'(nfree == NS && !m_dv && m_rv < 0));
      check("err_bad_tag", 128'(err_bad_tag), 128'(m_err));

      if (m_dv && dma_req_ready) $display("dma_req slot=%0d src=%h dst=%h size=%0d", m_dtag, m_dsrc, m_ddst, m_dsize);
      if (out_fire) $display("rsp requester=%0d tag=%h", m_rv, m_rtag);
    end

    if (!reset_n) begin
      for (int s = 0; s < NS; s++) begin m_used[s] = 1'b0; m_owner[s] = 0; m_otag[s] = '0; end
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_ptr = 0; m_dv = 1'b0; m_rv = -1; m_err = 1'b0;
      m_on  = 1'b1;
    end else if (m_on) begin
      if (out_fire) m_rv = -1;
      if (m_dv && dma_req_ready) m_dv = 1'b0;
      if (dma_rsp_valid && in_rdy) begin
        t = int'(dma_rsp_tag);
        if (m_used[t]) begin
          o = m_owner[t];
          m_rv = o; m_rtag = m_otag[t];
          m_used[t] = 1'b0;
          m_cnt[o]--;
        end else begin
          m_err = 1'b1;
        end
      end
      if (grant >= 0) begin
        m_dv    = 1'b1;
        m_dsrc  = req_src_addr[grant*32 +: 32];
        m_ddst  = req_dst_addr[grant*32 +: 32];
        m_dsize = req_size[grant*16 +: 16];
        m_ddir  = req_dir[grant];
        m_dtag  = 3'(slot);
        m_used[slot]  = 1'b1;
        m_owner[slot] = grant;
        m_otag[slot]  = req_tag[grant*8 +: 8];
        m_cnt[grant]++;
        m_ptr = (grant + 1) % NR;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] sz, input logic dir, input logic [7:0] tg);
    req_src_addr[i*32 +: 32] = src;
    req_dst_addr[i*32 +: 32] = dst;
    req_size[i*16 +: 16]     = sz;
    req_dir[i]               = dir;
    req_tag[i*8 +: 8]        = tg;
  endtask

  task automatic apply_reset();
    reset_n       = 1'b0;
    req_valid     = '0;
    dma_req_ready = 1'b1;
    dma_rsp_valid = 1'b0;
    dma_rsp_tag   = '0;
    rsp_ready     = '1;
    nxt();
    nxt();
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int used_list[$];
    req_src_addr = '0; req_dst_addr = '0; req_size = '0; req_dir = '0; req_tag = '0;

    // single request round trip
    apply_reset();
    smp();
    check("rst_idle", 128'(idle), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_dma_req_valid", 128'(dma_req_valid), 128'(0));
    check("rst_err", 128'(err_bad_tag), 128'(0));
    nxt(); set_req(0, 32'h1000, 32'h40, 16'd256, 1'b0, 8'h5A); req_valid = 4'b0001;
    smp(); check("t1_req_ready", 128'(req_ready), 128'(4'b0001));
    nxt(); req_valid = '0;
    smp(); check("t1_dma_valid", 128'(dma_req_valid), 128'(1));
    check("t1_dma_tag", 128'(dma_req_tag), 128'(0));
    check("t1_dma_src", 128'(dma_req_src_addr), 128'(32'h1000));
    check("t1_busy", 128'(busy), 128'(4'b0001));
    nxt(); dma_rsp_valid = 1'b1; dma_rsp_tag = 3'd0;
    smp(); check("t1_dma_rsp_ready", 128'(dma_rsp_ready), 128'(1));
    nxt(); dma_rsp_valid = 1'b0;
    smp(); check("t1_rsp_valid", 128'(rsp_valid), 128'(4'b0001));
    check("t1_rsp_tag", 128'(rsp_tag), 128'(8'h5A));
    check("t1_busy_clear", 128'(busy), 128'(0));
    nxt();
    smp(); check("t1_idle", 128'(idle), 128'(1));

    // per-requester limit
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      set_req(1, 32'h3000 + 32'(r), 32'h10, 16'd8, 1'b1, 8'(8'h20 + r)); req_valid = 4'b0010;
      smp(); check("t2_grant", 128'(req_ready), 128'(4'b0010));
      nxt();
    end
    set_req(2, 32'h4000, 32'h20, 16'd4, 1'b0, 8'h44); req_valid = 4'b0110;
    smp(); check("t2_skip_limited", 128'(req_ready), 128'(4'b0100));
    nxt(); req_valid = 4'b0010;
    smp(); check("t2_slot4", 128'(dma_req_tag), 128'(4));
    check("t2_held", 128'(req_ready), 128'(0));
    nxt(); dma_rsp_valid = 1'b1; dma_rsp_tag = 3'd2;
    smp(); check("t2_no_same_cycle", 128'(req_ready), 128'(0));
    nxt(); dma_rsp_valid = 1'b0;
    smp(); check("t2_after_free", 128'(req_ready), 128'(4'b0010));
    nxt(); req_valid = '0;
    smp(); check("t2_reuse_slot2", 128'(dma_req_tag), 128'(2));

    // fairness then slot exhaustion
    apply_reset();
    for (int i = 0; i < NR; i++) set_req(i, 32'h2000 + 32'(i*16), 32'h80 + 32'(i), 16'(16*(i+1)), i[0], 8'(8'h10 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      smp(); check("t3_rr_order", 128'(req_ready), 128'(1) << (k % 4));
      nxt();
    end
    smp(); check("t3_full", 128'(req_ready), 128'(0));
    nxt(); dma_rsp_valid = 1'b1; dma_rsp_tag = 3'd5;
    smp(); check("t3_free_same_cycle", 128'(req_ready), 128'(0));
    nxt(); dma_rsp_valid = 1'b0;
    smp(); check("t3_regrant", 128'(req_ready), 128'(4'b0001));
    check("t3_rsp_owner", 128'(rsp_valid), 128'(4'b0010));
    check("t3_rsp_tag", 128'(rsp_tag), 128'(8'h11));
    nxt(); req_valid = '0;
    smp(); check("t3_slot5", 128'(dma_req_tag), 128'(5));
    check("t3_src", 128'(dma_req_src_addr), 128'(32'h2000));

    // backpressure on both sides
    apply_reset();
    dma_req_ready = 1'b0;
    set_req(0, 32'hABC, 32'h1, 16'd2, 1'b0, 8'h31);
    set_req(1, 32'hDEF, 32'h2, 16'd3, 1'b1, 8'h32);
    req_valid = 4'b0001;
    smp(); check("t4_first", 128'(req_ready), 128'(4'b0001));
    nxt(); req_valid = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      smp(); check("t4_stall_valid", 128'(dma_req_valid), 128'(1));
      check("t4_stall_src", 128'(dma_req_src_addr), 128'(32'hABC));
      check("t4_stall_nogrant", 128'(req_ready), 128'(0));
      nxt();
    end
    dma_req_ready = 1'b1;
    smp(); check("t4_drain_grant", 128'(req_ready), 128'(4'b0010));
    nxt(); req_valid = '0; rsp_ready = '0; dma_rsp_valid = 1'b1; dma_rsp_tag = 3'd0;
    smp(); check("t4_rsp_accept", 128'(dma_rsp_ready), 128'(1));
    nxt(); dma_rsp_tag = 3'd1;
    smp(); check("t4_rsp_held", 128'(rsp_valid), 128'(4'b0001));
    check("t4_rsp_block", 128'(dma_rsp_ready), 128'(0));
    nxt(); rsp_ready = '1;
    smp(); check("t4_rsp_unblock", 128'(dma_rsp_ready), 128'(1));
    nxt(); dma_rsp_valid = 1'b0;
    smp(); check("t4_rsp2_valid", 128'(rsp_valid), 128'(4'b0010));
    check("t4_rsp2_tag", 128'(rsp_tag), 128'(8'h32));

    // bad tag and reset with transfers in flight
    apply_reset();
    for (int i = 0; i < 3; i++) set_req(i, 32'h5000, 32'h0, 16'd1, 1'b0, 8'(i));
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      smp(); check("t5_grant", 128'(req_ready), 128'(1) << k);
      nxt();
    end
    req_valid = '0; dma_rsp_valid = 1'b1; dma_rsp_tag = 3'd7;
    smp(); check("t5_bad_consumed", 128'(dma_rsp_ready), 128'(1));
    nxt(); dma_rsp_valid = 1'b0;
    smp(); check("t5_no_rsp", 128'(rsp_valid), 128'(0));
    check("t5_err", 128'(err_bad_tag), 128'(1));
    check("t5_busy", 128'(busy), 128'(4'b0111));
    nxt(); reset_n = 1'b0;
    smp();
    nxt(); reset_n = 1'b1;
    smp(); check("t5_idle", 128'(idle), 128'(1));
    check("t5_err_clear", 128'(err_bad_tag), 128'(0));
    check("t5_busy_clear", 128'(busy), 128'(0));

    // randomized traffic, checked by the model every cycle
    apply_reset();
    repeat (1500) begin
      req_valid     = 4'($urandom());
      req_src_addr  = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_dst_addr  = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_size      = {$urandom(), $urandom()};
      req_dir       = 4'($urandom());
      req_tag       = $urandom();
      dma_req_ready = ($urandom_range(0, 3) != 0);
      rsp_ready     = 4'($urandom());
      used_list = {};
      for (int s = 0; s < NS; s++) if (m_used[s]) used_list.push_back(s);
      if (used_list.size() > 0 && $urandom_range(0, 2) == 0) begin
        dma_rsp_valid = 1'b1;
        dma_rsp_tag   = 3'(used_list[$urandom_range(0, used_list.size() - 1)]);
      end else if ($urandom_range(0, 199) == 0) begin
        dma_rsp_valid = 1'b1;
        dma_rsp_tag   = 3'($urandom_range(0, 7));
      end else begin
        dma_rsp_valid = 1'b0;
      end
      nxt();
    end
    req_valid = '0; dma_rsp_valid = 1'b0;
    smp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
